// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_AUX = 1'b1;

   localparam int CNT_W    = 4;
   localparam int STREAK_W = 4;

   // Saturating increment used by the CPU streak counter.
   function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v,
                                                   input logic [STREAK_W-1:0] max);
      return (v == max) ? v : v + STREAK_W'(1);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection and CPU streak counter for mem_port_arbiter.
// With MEM_ARB_AUX_PRIO_EN defined, i_aux_prio makes aux win every contested pick.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int MAX_STREAK = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_cpu_req,
   input  logic i_aux_req,
`ifdef MEM_ARB_AUX_PRIO_EN
   input  logic i_aux_prio,
`endif
   input  logic i_arb_en,
   output logic o_grant_aux_next
);

   localparam logic [STREAK_W-1:0] LP_MAX = STREAK_W'(MAX_STREAK);

   logic [STREAK_W-1:0] r_streak;
   logic [STREAK_W-1:0] w_streak_nxt;
   logic                w_aux_win;
   logic                w_prio;

`ifdef MEM_ARB_AUX_PRIO_EN
   assign w_prio = i_aux_prio;
`else
   assign w_prio = 1'b0;
`endif

   always_comb begin
      w_aux_win    = GNT_CPU;
      w_streak_nxt = r_streak;
      if (i_aux_req && !i_cpu_req) begin
         w_aux_win = GNT_AUX;
      end else if (i_aux_req && i_cpu_req) begin
         w_aux_win = w_prio || (r_streak == LP_MAX);
      end
      // Streak only counts CPU wins that kept a pending aux waiting.
      if (w_prio) begin
         w_streak_nxt = '0;
      end else if (i_arb_en) begin
         if (w_aux_win || !i_aux_req) begin
            w_streak_nxt = '0;
         end else begin
            w_streak_nxt = sat_inc(r_streak, LP_MAX);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_streak <= '0;
      end else begin
         r_streak <= w_streak_nxt;
      end
   end

   assign o_grant_aux_next = w_aux_win;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU and auxiliary ports onto the single unified memory.
// Optional MEM_ARB_AUX_PRIO_EN adds an aux_prio input that favours the aux port.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1,
   parameter int MAX_STREAK  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_ready,
`ifdef MEM_ARB_AUX_PRIO_EN
   input  logic              aux_prio,
`endif
   output logic [DATA_W-1:0] rdata,
   output logic              grant_aux,
   output logic              busy,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("WAIT_CYCLES must be within 0..15");
   end
   if (MAX_STREAK < 1 || MAX_STREAK > 15) begin : g_bad_streak
      $error("MAX_STREAK must be within 1..15");
   end

   localparam logic [CNT_W-1:0] LP_WAIT = CNT_W'(WAIT_CYCLES);

   state_e              r_state;
   state_e              w_state_nxt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_grant_aux;
   logic [DATA_W-1:0]   r_rdata;

   logic                w_arb_en;
   logic                w_grant_aux_nxt;
   logic                w_acc_last;
   logic                w_mem_rd;
   logic                w_mem_wr;
   logic                w_cpu_rdy;
   logic                w_aux_rdy;

   assign w_arb_en   = (r_state == IDLE) && (cpu_req || aux_req);
   assign w_acc_last = (r_state == ACC) && (r_cnt == '0);

   mem_arb_pick #(
      .MAX_STREAK(MAX_STREAK)
   ) u_pick (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_cpu_req       (cpu_req),
      .i_aux_req       (aux_req),
`ifdef MEM_ARB_AUX_PRIO_EN
      .i_aux_prio      (aux_prio),
`endif
      .i_arb_en        (w_arb_en),
      .o_grant_aux_next(w_grant_aux_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mem_rd    = 1'b0;
      w_mem_wr    = 1'b0;
      w_cpu_rdy   = 1'b0;
      w_aux_rdy   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_arb_en) begin
               w_state_nxt = ACC;
            end
         end
         ACC: begin
            w_mem_rd = !r_we;
            w_mem_wr = r_we;
            if (r_cnt == '0) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            // Requests are not looked at here; a held req restarts from IDLE.
            w_cpu_rdy   = (r_grant_aux == GNT_CPU);
            w_aux_rdy   = (r_grant_aux == GNT_AUX);
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_grant_aux <= GNT_CPU;
         r_rdata     <= '0;
      end else begin
         if (w_arb_en) begin
            r_grant_aux <= w_grant_aux_nxt;
            r_cnt       <= LP_WAIT;
            if (w_grant_aux_nxt == GNT_AUX) begin
               r_we    <= aux_we;
               r_addr  <= aux_addr;
               r_wdata <= aux_wdata;
            end else begin
               r_we    <= cpu_we;
               r_addr  <= cpu_addr;
               r_wdata <= cpu_wdata;
            end
         end else if ((r_state == ACC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         // Only reads refresh rdata; writes leave the last read visible.
         if (w_acc_last && !r_we) begin
            r_rdata <= mem_rdata;
         end
      end
   end

   assign cpu_ready = w_cpu_rdy;
   assign aux_ready = w_aux_rdy;
   assign rdata     = r_rdata;
   assign grant_aux = r_grant_aux;
   assign busy      = (r_state == ACC) || (r_state == RESP);
   assign mem_rd    = w_mem_rd;
   assign mem_wr    = w_mem_wr;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle 32-bit processor between two requesters: the CPU port and an auxiliary port (DMA/program loader).
- The CPU port is driven by the controller's memRead/memWrite/IorD-selected address.
- Sequences each access through a fixed, parameterised number of memory wait cycles and returns a one-cycle ready pulse.
- CPU has priority; a streak limit guarantees auxiliary progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 1, extra memory cycles per access (0..15).
- MAX_STREAK, 4, consecutive CPU grants allowed while aux is pending (1..15).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request, level
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  one-cycle completion pulse to CPU
- aux_req  in  1  aux access request, level
- aux_we  in  1  aux write/read
- aux_addr  in  ADDR_W  aux address
- aux_wdata  in  DATA_W  aux write data
- aux_ready  out  1  one-cycle completion pulse to aux
- rdata  out  DATA_W  registered read data, valid with ready
- grant_aux  out  1  current/last grant owner (1 = aux)
- busy  out  1  high in ACC and RESP
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the last ACC cycle

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset state: IDLE. All outputs 0; internal address/wdata/we latches, wait counter and streak counter cleared.
- FSM states: IDLE, ACC, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: arbitrate, latch the winner's we/addr/wdata, set grant_aux, load cnt=WAIT_CYCLES, go to ACC.
- ACC:
  - mem_addr/mem_wdata are driven from the latches.
  - mem_rd = !we, mem_wr = we, asserted for every ACC cycle (WAIT_CYCLES+1 cycles).
  - cnt!=0: decrement, stay in ACC.
  - cnt==0: on a read, capture mem_rdata into rdata; go to RESP.
- RESP:
  - Raise exactly one of cpu_ready/aux_ready (per grant) for one cycle; mem strobes are 0.
  - Always go to IDLE.
  - Requests are ignored in RESP.
- Latency: request seen in IDLE at cycle N; ACC covers N+1..N+1+WAIT_CYCLES; ready at N+2+WAIT_CYCLES. Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- Handshake:
  - Requester holds req and its fields stable until it samples ready.
  - req still high in the cycle after ready is a new transaction.
  - The latched fields are used, so changes after grant have no effect.
- Writes leave rdata unchanged. rdata holds its value until the next read completes.
- Arbitration (IDLE only):
  - Only one requester high: it wins.
  - Both high: CPU wins unless streak==MAX_STREAK, in which case aux wins.
  - streak increments on a CPU grant while aux_req=1 (saturating at MAX_STREAK).
  - streak clears on any aux grant, or on a CPU grant with aux_req=0.
- Simultaneous req deassert during ACC: the access still completes and ready still pulses.
- Reset mid-access: immediate return to IDLE; strobes drop asynchronously; no ready is issued. The memory write may be partial, which is acceptable.
- Width rules: cnt is 4 bits; streak is 4 bits; parameter ranges are checked by elaboration assertion.

Optional Feature:
- Macro MEM_ARB_AUX_PRIO_EN.
- Defined: adds input aux_prio (1 bit). When aux_prio=1, aux wins every contested arbitration and streak is held at 0; when aux_prio=0, behaviour is as above.
- Undefined: no aux_prio port; arbitration exactly as specified.

Decomposition:
- Shared package mem_arb_pkg:
  - State enum: IDLE=2'd0, ACC=2'd1, RESP=2'd2.
  - Grant constants: GNT_CPU=1'b0, GNT_AUX=1'b1.
  - Width constants CNT_W=4, STREAK_W=4.
- One sub-module, mem_arb_pick: combinational winner selection plus the streak counter register (clk/rst_n). It outputs grant_aux_next.
- FSM, latches and counters stay in the top module.

Test Plan:
- WAIT_CYCLES=1; CPU read addr 0x10, mem_rdata=0xDEADBEEF -> mem_rd high cycles 1-2, cpu_ready at cycle 3, rdata=0xDEADBEEF, aux_ready stays 0.
- Aux write addr 0x40 data 0x12345678 -> mem_wr high 2 cycles with mem_addr=0x40 and mem_wdata=0x12345678, aux_ready once, rdata unchanged.
- MAX_STREAK=4; cpu_req and aux_req held high continuously -> grant order CPU,CPU,CPU,CPU,AUX, repeating; every ready is a single-cycle pulse.
- cpu_req held high across ready -> second access starts the cycle after RESP; cpu_addr changed during ACC does not alter mem_addr.
- rst_n low during the second ACC cycle of a write -> mem_wr drops immediately, no ready; after release the FSM is IDLE and all outputs are 0.
- MEM_ARB_AUX_PRIO_EN defined, aux_prio=1, both requesting -> aux wins every arbitration; aux_prio=0 restores the CPU-priority/streak order.
